// File: rtl/rv32i_line_cache_if.sv
// CPU word handshake plus 256-bit physical-memory line handshake for rv32i_line_cache.
// The slave modport is the cache side; the master modport is the CPU/memory side.
interface rv32i_line_cache_if;
  logic [31:0]  mem_address;
  logic         mem_read;
  logic         mem_write;
  logic [3:0]   mem_byte_enable;
  logic [31:0]  mem_wdata;
  logic [31:0]  mem_rdata;
  logic         mem_resp;
  logic [31:0]  pmem_address;
  logic         pmem_read;
  logic         pmem_write;
  logic [255:0] pmem_wdata;
  logic [255:0] pmem_rdata;
  logic         pmem_resp;

  modport slave (
    input  mem_address, mem_read, mem_write, mem_byte_enable, mem_wdata, pmem_rdata, pmem_resp,
    output mem_rdata, mem_resp, pmem_address, pmem_read, pmem_write, pmem_wdata
  );

  modport master (
    output mem_address, mem_read, mem_write, mem_byte_enable, mem_wdata, pmem_rdata, pmem_resp,
    input  mem_rdata, mem_resp, pmem_address, pmem_read, pmem_write, pmem_wdata
  );
endinterface

// File: rtl/rv32i_line_cache.sv
// Direct-mapped write-back/write-allocate cache with 256-bit lines and flop storage.
// Define CACHE_STATS_EN to add hit_count/miss_count outputs.
module rv32i_line_cache #(
  parameter int SETS = 8
) (
  input  logic                clk,
  input  logic                rst,
  rv32i_line_cache_if.slave   bus
`ifdef CACHE_STATS_EN
  ,
  output logic [31:0]         hit_count,
  output logic [31:0]         miss_count
`endif
);
  localparam int IDX  = $clog2(SETS);
  localparam int TAGW = 32 - 5 - IDX;

  typedef enum logic [1:0] {
    S_COMPARE   = 2'd0,
    S_WRITEBACK = 2'd1,
    S_ALLOCATE  = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [255:0]     r_data [SETS];
  logic [TAGW-1:0]  r_tag  [SETS];
  logic [SETS-1:0]  r_valid;
  logic [SETS-1:0]  r_dirty;

  logic [IDX-1:0]   w_idx;
  logic [TAGW-1:0]  w_tag;
  logic [2:0]       w_word;
  logic             w_req;
  logic             w_hit;
  logic             w_victim_dirty;
  logic             w_fill;
  logic             w_store;
  logic             w_wb_done;
  logic             w_unused;

  logic [31:0]      w_mem_rdata;
  logic             w_mem_resp;
  logic [31:0]      w_pmem_address;
  logic             w_pmem_read;
  logic             w_pmem_write;
  logic [255:0]     w_pmem_wdata;

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_w,
                                              input logic [31:0] new_w,
                                              input logic [3:0]  be);
    logic [31:0] res;
    res = old_w;
    for (int b = 0; b < 4; b++) begin
      if (be[b]) begin
        res[b*8 +: 8] = new_w[b*8 +: 8];
      end else begin
        res[b*8 +: 8] = old_w[b*8 +: 8];
      end
    end
    return res;
  endfunction

  assign w_idx          = bus.mem_address[4+IDX:5];
  assign w_tag          = bus.mem_address[31:5+IDX];
  assign w_word         = bus.mem_address[4:2];
  assign w_req          = bus.mem_read | bus.mem_write;
  assign w_hit          = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
  assign w_victim_dirty = r_valid[w_idx] && r_dirty[w_idx];
  assign w_unused       = ^bus.mem_address[1:0];

  // A write with mem_write set wins over a simultaneous read; empty byte enables change nothing.
  assign w_store   = !rst && (r_state == S_COMPARE) && w_req && w_hit && bus.mem_write
                     && (bus.mem_byte_enable != 4'b0000);
  assign w_fill    = !rst && (r_state == S_ALLOCATE) && bus.pmem_resp;
  assign w_wb_done = !rst && (r_state == S_WRITEBACK) && bus.pmem_resp;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_COMPARE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_COMPARE: begin
        if (w_req && !w_hit) begin
          w_next = w_victim_dirty ? S_WRITEBACK : S_ALLOCATE;
        end else begin
          w_next = S_COMPARE;
        end
      end
      S_WRITEBACK: begin
        if (bus.pmem_resp) begin
          w_next = S_ALLOCATE;
        end else begin
          w_next = S_WRITEBACK;
        end
      end
      S_ALLOCATE: begin
        if (bus.pmem_resp) begin
          w_next = S_COMPARE;
        end else begin
          w_next = S_ALLOCATE;
        end
      end
      default: w_next = S_COMPARE;
    endcase
  end

  // Output logic; everything is forced idle while rst is high.
  always_comb begin
    w_mem_rdata    = 32'd0;
    w_mem_resp     = 1'b0;
    w_pmem_address = 32'd0;
    w_pmem_read    = 1'b0;
    w_pmem_write   = 1'b0;
    w_pmem_wdata   = 256'd0;
    if (rst) begin
      w_mem_resp = 1'b0;
    end else begin
      case (r_state)
        S_COMPARE: begin
          if (w_req && w_hit) begin
            w_mem_resp  = 1'b1;
            w_mem_rdata = bus.mem_write ? 32'd0 : r_data[w_idx][{w_word, 5'd0} +: 32];
          end else begin
            w_mem_resp = 1'b0;
          end
        end
        S_WRITEBACK: begin
          w_pmem_write   = 1'b1;
          w_pmem_address = {r_tag[w_idx], w_idx, 5'd0};
          w_pmem_wdata   = r_data[w_idx];
        end
        S_ALLOCATE: begin
          w_pmem_read    = 1'b1;
          w_pmem_address = {bus.mem_address[31:5], 5'd0};
        end
        default: w_mem_resp = 1'b0;
      endcase
    end
  end

  assign bus.mem_rdata    = w_mem_rdata;
  assign bus.mem_resp     = w_mem_resp;
  assign bus.pmem_address = w_pmem_address;
  assign bus.pmem_read    = w_pmem_read;
  assign bus.pmem_write   = w_pmem_write;
  assign bus.pmem_wdata   = w_pmem_wdata;

  // Line data and tag storage; deliberately not cleared by reset.
  always_ff @(posedge clk) begin
    if (w_fill) begin
      r_data[w_idx] <= bus.pmem_rdata;
      r_tag[w_idx]  <= w_tag;
    end else if (w_store) begin
      r_data[w_idx][{w_word, 5'd0} +: 32] <=
        merge_bytes(r_data[w_idx][{w_word, 5'd0} +: 32], bus.mem_wdata, bus.mem_byte_enable);
    end
  end

  // Valid and dirty bits.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= '0;
      r_dirty <= '0;
    end else if (w_fill) begin
      r_valid[w_idx] <= 1'b1;
      r_dirty[w_idx] <= 1'b0;
    end else if (w_wb_done) begin
      r_dirty[w_idx] <= 1'b0;
    end else if (w_store) begin
      r_dirty[w_idx] <= 1'b1;
    end
  end

`ifdef CACHE_STATS_EN
  logic r_refill;

  // The COMPARE cycle right after a fill is the re-hit of a miss, so it is not a hit.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_refill   <= 1'b0;
      hit_count  <= 32'd0;
      miss_count <= 32'd0;
    end else begin
      r_refill <= w_fill;
      if ((r_state == S_COMPARE) && w_req && w_hit && !r_refill) begin
        hit_count <= hit_count + 32'd1;
      end
      if ((r_state == S_COMPARE) && w_req && !w_hit) begin
        miss_count <= miss_count + 32'd1;
      end
    end
  end
`endif
endmodule

// File: tb/tb_rv32i_line_cache.sv
// Self-checking bench for rv32i_line_cache: directed scenarios plus randomized traffic
// checked against a set-level cache model over a word-addressed backing memory.
module tb_rv32i_line_cache;
  localparam int SETS = 8;
  localparam int IDX  = 3;
  localparam int TAGW = 32 - 5 - IDX;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;

  rv32i_line_cache_if bus ();
`ifdef CACHE_STATS_EN
  logic [31:0] hit_count;
  logic [31:0] miss_count;
`endif

  rv32i_line_cache #(.SETS(SETS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef CACHE_STATS_EN
    ,
    .hit_count  (hit_count),
    .miss_count (miss_count)
`endif
  );

  always #5 clk = ~clk;

  // Reference model: backing memory by word address, cache contents by set.
  bit [31:0]      bmem [bit [29:0]];
  bit             m_valid [SETS];
  bit             m_dirty [SETS];
  bit [TAGW-1:0]  m_tag   [SETS];
  bit [31:0]      m_line  [SETS][8];

  function automatic bit [31:0] mem_word(input bit [29:0] wa);
    if (!bmem.exists(wa)) bmem[wa] = $urandom;
    return bmem[wa];
  endfunction

  function automatic logic [255:0] line_of(input logic [31:0] la);
    logic [255:0] l;
    for (int k = 0; k < 8; k++) l[k*32 +: 32] = mem_word({la[31:5], 3'(k)});
    return l;
  endfunction

  task automatic model_reset();
    for (int s = 0; s < SETS; s++) begin
      m_valid[s] = 1'b0;
      m_dirty[s] = 1'b0;
    end
  endtask

  task automatic model_access(input bit [31:0] a, input bit we, input bit [3:0] be, input bit [31:0] wd,
                              output bit hit, output bit wb, output bit [31:0] wb_addr,
                              output bit [255:0] wb_line, output bit [31:0] rd);
    bit [IDX-1:0]  s;
    bit [TAGW-1:0] t;
    bit [2:0]      w;
    s = a[4+IDX:5];
    t = a[31:5+IDX];
    w = a[4:2];
    hit     = m_valid[s] && (m_tag[s] == t);
    wb      = !hit && m_valid[s] && m_dirty[s];
    wb_addr = 32'd0;
    wb_line = 256'd0;
    if (wb) begin
      wb_addr = {m_tag[s], s, 5'd0};
      for (int k = 0; k < 8; k++) begin
        wb_line[k*32 +: 32] = m_line[s][k];
        bmem[{m_tag[s], s, 3'(k)}] = m_line[s][k];
      end
    end
    if (!hit) begin
      for (int k = 0; k < 8; k++) m_line[s][k] = mem_word({a[31:5], 3'(k)});
      m_valid[s] = 1'b1;
      m_tag[s]   = t;
      m_dirty[s] = 1'b0;
    end
    rd = m_line[s][w];
    if (we && (be != 4'b0000)) begin
      for (int b = 0; b < 4; b++) if (be[b]) m_line[s][w][b*8 +: 8] = wd[b*8 +: 8];
      m_dirty[s] = 1'b1;
    end
  endtask

  // Drives one CPU request (entered and left at a negedge), plays physical memory with
  // the given extra wait cycles, and reports what was observed.
  task automatic run_access(input bit [31:0] a, input bit we, input bit [3:0] be, input bit [31:0] wd,
                            input int dw, input int df,
                            output bit got, output int cyc, output bit [31:0] rd,
                            output int n_wb, output bit [31:0] wb_a, output bit [255:0] wb_d,
                            output int n_fill, output bit [31:0] fill_a, output bit both);
    int wait_cnt;
    bit prev_rd, prev_wr;
    got = 0; cyc = 0; rd = 0; n_wb = 0; wb_a = 0; wb_d = 0; n_fill = 0; fill_a = 0; both = 0;
    wait_cnt = 0; prev_rd = 0; prev_wr = 0;
    bus.mem_address     = a;
    bus.mem_read        = !we;
    bus.mem_write       = we;
    bus.mem_byte_enable = be;
    bus.mem_wdata       = wd;
    for (int c = 0; c < 200; c++) begin
      #1;
      bus.pmem_resp  = 1'b0;
      bus.pmem_rdata = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      if (bus.pmem_read && bus.pmem_write) both = 1;
      if (bus.mem_resp) begin
        got = 1;
        cyc = c;
        rd  = bus.mem_rdata;
        break;
      end
      if (bus.pmem_write) begin
        if (!prev_wr) begin
          n_wb++;
          wb_a = bus.pmem_address;
          wb_d = bus.pmem_wdata;
          wait_cnt = 0;
        end
        if (wait_cnt == dw) bus.pmem_resp = 1'b1;
        wait_cnt++;
      end else if (bus.pmem_read) begin
        if (!prev_rd) begin
          n_fill++;
          fill_a = bus.pmem_address;
          wait_cnt = 0;
        end
        if (wait_cnt == df) begin
          bus.pmem_resp  = 1'b1;
          bus.pmem_rdata = line_of(bus.pmem_address);
        end
        wait_cnt++;
      end
      prev_rd = bus.pmem_read;
      prev_wr = bus.pmem_write;
      @(negedge clk);
    end
    bus.pmem_resp = 1'b0;
    @(negedge clk);
    bus.mem_read  = 1'b0;
    bus.mem_write = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.mem_address = 32'h40;
    bus.mem_read    = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    n_checks++;
    if (bus.mem_resp !== 1'b0 || bus.pmem_read !== 1'b0 || bus.pmem_write !== 1'b0 || bus.mem_rdata !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: resp=%b pread=%b pwrite=%b rdata=%h, required all zero",
               bus.mem_resp, bus.pmem_read, bus.pmem_write, bus.mem_rdata);
    end
    @(negedge clk);
    rst = 1'b0;
    bus.mem_read = 1'b0;
    model_reset();
    @(negedge clk);
  endtask

  task automatic test_clean_miss();
    bit got, both, hit, wb; int cyc, nwb, nfill;
    bit [31:0] rd, wba, fa, ewa, erd; bit [255:0] wbd, ewd;
    bmem[30'h10] = 32'h11111111;
    model_access(32'h40, 1'b0, 4'h0, 32'h0, hit, wb, ewa, ewd, erd);
    run_access(32'h40, 1'b0, 4'h0, 32'h0, 0, 3, got, cyc, rd, nwb, wba, wbd, nfill, fa, both);
    n_checks++;
    if (!got || cyc != 5) begin n_fail++; $display("FAIL clean_miss_latency: got=%b cycles=%0d, required 1/5", got, cyc); end
    n_checks++;
    if (rd !== 32'h11111111) begin n_fail++; $display("FAIL clean_miss_rdata: %h, required 11111111", rd); end
    n_checks++;
    if (nfill != 1 || fa !== 32'h40) begin n_fail++; $display("FAIL clean_miss_fill: n=%0d addr=%h, required 1/00000040", nfill, fa); end
    n_checks++;
    if (nwb != 0) begin n_fail++; $display("FAIL clean_miss_no_wb: %0d writebacks, required 0", nwb); end
  endtask

  task automatic test_hit_read();
    bit got, both, hit, wb; int cyc, nwb, nfill;
    bit [31:0] rd, wba, fa, ewa, erd; bit [255:0] wbd, ewd;
    model_access(32'h44, 1'b0, 4'h0, 32'h0, hit, wb, ewa, ewd, erd);
    run_access(32'h44, 1'b0, 4'h0, 32'h0, 0, 0, got, cyc, rd, nwb, wba, wbd, nfill, fa, both);
    n_checks++;
    if (!got || cyc != 0) begin n_fail++; $display("FAIL hit_read_latency: got=%b cycles=%0d, required 1/0", got, cyc); end
    n_checks++;
    if (rd !== bmem[30'h11]) begin n_fail++; $display("FAIL hit_read_rdata: %h, required %h", rd, bmem[30'h11]); end
    n_checks++;
    if (nwb != 0 || nfill != 0) begin n_fail++; $display("FAIL hit_read_pmem: wb=%0d fill=%0d, required 0/0", nwb, nfill); end
  endtask

  task automatic test_write_hit();
    bit got, both, hit, wb; int cyc, nwb, nfill;
    bit [31:0] rd, wba, fa, ewa, erd, l2, want; bit [255:0] wbd, ewd;
    model_access(32'h48, 1'b1, 4'b0100, 32'hAABBCCDD, hit, wb, ewa, ewd, erd);
    run_access(32'h48, 1'b1, 4'b0100, 32'hAABBCCDD, 0, 0, got, cyc, rd, nwb, wba, wbd, nfill, fa, both);
    n_checks++;
    if (!got || cyc != 0 || nwb != 0 || nfill != 0) begin
      n_fail++;
      $display("FAIL write_hit: got=%b cycles=%0d wb=%0d fill=%0d, required 1/0/0/0", got, cyc, nwb, nfill);
    end
    l2   = bmem[30'h12];
    want = {l2[31:24], 8'hBB, l2[15:0]};
    model_access(32'h48, 1'b0, 4'h0, 32'h0, hit, wb, ewa, ewd, erd);
    run_access(32'h48, 1'b0, 4'h0, 32'h0, 0, 0, got, cyc, rd, nwb, wba, wbd, nfill, fa, both);
    n_checks++;
    if (!got || cyc != 0 || rd !== want) begin
      n_fail++;
      $display("FAIL write_readback: got=%b cycles=%0d rdata=%h, required 1/0/%h", got, cyc, rd, want);
    end
  endtask

  task automatic test_dirty_evict();
    bit got, both, hit, wb; int cyc, nwb, nfill;
    bit [31:0] rd, wba, fa, ewa, erd, w; bit [255:0] wbd, ewd, want;
    for (int k = 0; k < 8; k++) begin
      w = mem_word(30'h10 + 30'(k));
      want[k*32 +: 32] = (k == 2) ? {w[31:24], 8'hBB, w[15:0]} : w;
    end
    model_access(32'h148, 1'b0, 4'h0, 32'h0, hit, wb, ewa, ewd, erd);
    run_access(32'h148, 1'b0, 4'h0, 32'h0, 1, 2, got, cyc, rd, nwb, wba, wbd, nfill, fa, both);
    n_checks++;
    if (nwb != 1 || wba !== 32'h40) begin n_fail++; $display("FAIL evict_wb_addr: n=%0d addr=%h, required 1/00000040", nwb, wba); end
    n_checks++;
    if (wbd !== want) begin n_fail++; $display("FAIL evict_wb_data: %h, required %h", wbd, want); end
    n_checks++;
    if (nfill != 1 || fa !== 32'h140) begin n_fail++; $display("FAIL evict_fill: n=%0d addr=%h, required 1/00000140", nfill, fa); end
    n_checks++;
    if (!got || cyc != 6 || rd !== erd || both) begin
      n_fail++;
      $display("FAIL evict_resp: got=%b cycles=%0d rdata=%h both=%b, required 1/6/%h/0", got, cyc, rd, both, erd);
    end
  endtask

  task automatic test_reset_mid_fill();
    bit seen, got, both, hit, wb; int cyc, nwb, nfill;
    bit [31:0] rd, wba, fa, ewa, erd; bit [255:0] wbd, ewd;
    seen = 0;
    bus.mem_address = 32'h40;
    bus.mem_read    = 1'b1;
    for (int c = 0; c < 10; c++) begin
      #1;
      if (bus.pmem_read) begin seen = 1; break; end
      @(negedge clk);
    end
    n_checks++;
    if (!seen) begin n_fail++; $display("FAIL midfill_request: pmem_read=0, required 1"); end
    @(negedge clk);
    rst = 1'b1;
    bus.mem_read = 1'b0;
    #1;
    n_checks++;
    if (bus.pmem_read !== 1'b0 || bus.mem_resp !== 1'b0) begin
      n_fail++;
      $display("FAIL midfill_during_rst: pread=%b resp=%b, required 0/0", bus.pmem_read, bus.mem_resp);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_checks++;
    if (bus.pmem_read !== 1'b0 || bus.pmem_write !== 1'b0) begin
      n_fail++;
      $display("FAIL midfill_after_rst: pread=%b pwrite=%b, required 0/0", bus.pmem_read, bus.pmem_write);
    end
    @(negedge clk);
    model_reset();
    model_access(32'h40, 1'b0, 4'h0, 32'h0, hit, wb, ewa, ewd, erd);
    run_access(32'h40, 1'b0, 4'h0, 32'h0, 0, 1, got, cyc, rd, nwb, wba, wbd, nfill, fa, both);
    n_checks++;
    if (nfill != 1 || fa !== 32'h40 || nwb != 0) begin
      n_fail++;
      $display("FAIL midfill_remiss: fill=%0d addr=%h wb=%0d, required 1/00000040/0", nfill, fa, nwb);
    end
    n_checks++;
    if (!got || rd !== erd) begin n_fail++; $display("FAIL midfill_rdata: got=%b rdata=%h, required 1/%h", got, rd, erd); end
  endtask

  task automatic test_spurious_resp();
    bit got, both, hit, wb; int cyc, nwb, nfill;
    bit [31:0] rd, wba, fa, ewa, erd; bit [255:0] wbd, ewd;
    bus.pmem_rdata = {8{32'hDEADBEEF}};
    bus.pmem_resp  = 1'b1;
    @(negedge clk);
    bus.pmem_resp  = 1'b0;
    model_access(32'h44, 1'b0, 4'h0, 32'h0, hit, wb, ewa, ewd, erd);
    run_access(32'h44, 1'b0, 4'h0, 32'h0, 0, 0, got, cyc, rd, nwb, wba, wbd, nfill, fa, both);
    n_checks++;
    if (!got || cyc != 0 || rd !== erd) begin
      n_fail++;
      $display("FAIL spurious_resp: got=%b cycles=%0d rdata=%h, required 1/0/%h", got, cyc, rd, erd);
    end
  endtask

  task automatic test_random();
    bit got, both, hit, wb, we; int cyc, nwb, nfill, dw, df, want_cyc;
    bit [31:0] a, wd, rd, wba, fa, ewa, erd; bit [255:0] wbd, ewd; bit [3:0] be;
    for (int i = 0; i < 300; i++) begin
      a  = {TAGW'($urandom_range(0, 3)), IDX'($urandom_range(0, SETS - 1)), 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3))};
      we = ($urandom_range(0, 2) == 0);
      be = 4'($urandom_range(0, 15));
      wd = $urandom;
      dw = $urandom_range(0, 3);
      df = $urandom_range(0, 3);
      model_access(a, we, be, wd, hit, wb, ewa, ewd, erd);
      want_cyc = hit ? 0 : (wb ? 3 + dw + df : 2 + df);
      run_access(a, we, be, wd, dw, df, got, cyc, rd, nwb, wba, wbd, nfill, fa, both);
      n_checks++;
      if (!got || cyc != want_cyc) begin
        n_fail++;
        $display("FAIL rand_latency[%0d] addr=%h: got=%b cycles=%0d, required 1/%0d", i, a, got, cyc, want_cyc);
      end
      if (!we) begin
        n_checks++;
        if (rd !== erd) begin n_fail++; $display("FAIL rand_rdata[%0d] addr=%h: %h, required %h", i, a, rd, erd); end
      end
      n_checks++;
      if (nwb != int'(wb) || (wb && (wba !== ewa || wbd !== ewd))) begin
        n_fail++;
        $display("FAIL rand_wb[%0d] addr=%h: n=%0d wa=%h wd=%h, required %0d/%h/%h", i, a, nwb, wba, wbd, wb, ewa, ewd);
      end
      n_checks++;
      if (nfill != int'(!hit) || (!hit && fa !== {a[31:5], 5'd0})) begin
        n_fail++;
        $display("FAIL rand_fill[%0d] addr=%h: n=%0d fa=%h, required %0d/%h", i, a, nfill, fa, !hit, {a[31:5], 5'd0});
      end
      n_checks++;
      if (both) begin n_fail++; $display("FAIL rand_exclusive[%0d]: pmem_read and pmem_write both high, required never", i); end
    end
  endtask

  initial begin
    rst                 = 1'b1;
    bus.mem_address     = 32'd0;
    bus.mem_read        = 1'b0;
    bus.mem_write       = 1'b0;
    bus.mem_byte_enable = 4'd0;
    bus.mem_wdata       = 32'd0;
    bus.pmem_rdata      = 256'd0;
    bus.pmem_resp       = 1'b0;
    @(negedge clk);
    test_reset();
    test_clean_miss();
    test_hit_read();
    test_write_hit();
    test_dirty_evict();
    test_reset_mid_fill();
    test_spurious_resp();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
